// File: rtl/sne_evt_stream_pkg.sv
// Shared event-stream types for the engine datapath: the event word carried
// on every SNE_EVENT_STREAM link and the group dispatcher state encoding.
package sne_evt_stream_pkg;

    localparam int unsigned EVT_TS_W = 12;
    localparam int unsigned EVT_XY_W = 8;
    localparam int unsigned EVT_OP_W = 4;

    typedef struct packed {
        logic [EVT_OP_W-1:0] op;
        logic [EVT_XY_W-1:0] y;
        logic [EVT_XY_W-1:0] x;
        logic [EVT_TS_W-1:0] ts;
    } sne_evt_t;

    localparam sne_evt_t SNE_EVT_NULL = '0;

    typedef enum logic {
        IDLE = 1'b0,
        FORK = 1'b1
    } evt_dispatch_state_e;

endpackage

// File: rtl/sne_event_stream_if.sv
// Valid/ready event stream link between datapath stages.
interface SNE_EVENT_STREAM;
    import sne_evt_stream_pkg::*;

    sne_evt_t evt;
    logic     valid;
    logic     ready;

    modport src (output evt, output valid, input ready);
    modport dst (input evt, input valid, output ready);

endinterface

// File: rtl/evt_dispatch_counter.sv
// Wrapping status counter; a clear wins over a same-cycle increment.
module evt_dispatch_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 engine_clk_i,
    input  logic                 engine_rst_ni,
    input  logic                 clr_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // count up on inc_i, wrap naturally, clear has priority
    always_ff @(posedge engine_clk_i or negedge engine_rst_ni) begin
        if (!engine_rst_ni) begin
            count_o <= '0;
        end else if (clr_i) begin
            count_o <= '0;
        end else if (inc_i) begin
            count_o <= count_o + ONE;
        end
    end

endmodule

// File: rtl/evt_group_dispatcher.sv
// Forks the engine event stream to N_GROUPS group filter streams. Each event
// is delivered once to every group enabled when it was accepted; the input is
// released only after all of those groups have taken it.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | nothing held; input ready follows en_i
//   FORK  | evt_q held, pending marks groups still owed it; input ready only
//         | once every remaining pending group handshakes this cycle
module evt_group_dispatcher
    import sne_evt_stream_pkg::*;
#(
    parameter int unsigned N_GROUPS  = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 engine_clk_i,
    input  logic                 engine_rst_ni,
    input  logic                 en_i,
    input  logic [N_GROUPS-1:0]  group_en_i,
    input  logic                 clr_i,
    SNE_EVENT_STREAM.dst         evt_dp_stream_dispatch_dst,
    SNE_EVENT_STREAM.src         evt_dp_stream_group_src [N_GROUPS],
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] evt_count_o,
    output logic [CNT_WIDTH-1:0] drop_count_o,
    output logic [CNT_WIDTH-1:0] stall_count_o
);

    evt_dispatch_state_e state_q;
    sne_evt_t            evt_q;
    logic [N_GROUPS-1:0] pending_q;

    logic [N_GROUPS-1:0] group_ready;
    logic [N_GROUPS-1:0] hs;
    logic [N_GROUPS-1:0] still_owed;
    logic                in_ready;
    logic                accept;
    logic                accept_evt;
    logic                accept_drop;
    logic                stall;

    // per-group fan-out: valid straight from the registered pending bit so a
    // raised valid can only fall through its own handshake or reset
    for (genvar g = 0; g < N_GROUPS; g++) begin : g_fork
        assign evt_dp_stream_group_src[g].valid = pending_q[g];
        assign evt_dp_stream_group_src[g].evt   = evt_q;
        assign group_ready[g]                   = evt_dp_stream_group_src[g].ready;
    end

    assign hs          = pending_q & group_ready;
    assign still_owed  = pending_q & ~hs;
    assign in_ready    = en_i && ((state_q == IDLE) || (still_owed == '0));
    assign accept      = evt_dp_stream_dispatch_dst.valid && in_ready;
    assign accept_evt  = accept && (group_en_i != '0);
    assign accept_drop = accept && (group_en_i == '0);
    assign stall       = (state_q == FORK) && ((pending_q & ~group_ready) != '0);

    assign evt_dp_stream_dispatch_dst.ready = in_ready;
    assign busy_o                           = (state_q == FORK);

    // dispatcher FSM: load on accept, retire pending bits on handshakes
    always_ff @(posedge engine_clk_i or negedge engine_rst_ni) begin
        if (!engine_rst_ni) begin
            state_q   <= IDLE;
            evt_q     <= SNE_EVT_NULL;
            pending_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        evt_q     <= evt_dp_stream_dispatch_dst.evt;
                        pending_q <= group_en_i;
                        state_q   <= (group_en_i != '0) ? FORK : IDLE;
                    end
                end
                FORK: begin
                    if (accept) begin
                        // last owed handshakes coincide with a new accept
                        evt_q     <= evt_dp_stream_dispatch_dst.evt;
                        pending_q <= group_en_i;
                        state_q   <= (group_en_i != '0) ? FORK : IDLE;
                    end else begin
                        pending_q <= still_owed;
                        if (still_owed == '0) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    pending_q <= '0;
                end
            endcase
        end
    end

    evt_dispatch_counter #(.CNT_WIDTH(CNT_WIDTH)) u_evt_cnt (
        .engine_clk_i  (engine_clk_i),
        .engine_rst_ni (engine_rst_ni),
        .clr_i         (clr_i),
        .inc_i         (accept_evt),
        .count_o       (evt_count_o)
    );

    evt_dispatch_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
        .engine_clk_i  (engine_clk_i),
        .engine_rst_ni (engine_rst_ni),
        .clr_i         (clr_i),
        .inc_i         (accept_drop),
        .count_o       (drop_count_o)
    );

    evt_dispatch_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .engine_clk_i  (engine_clk_i),
        .engine_rst_ni (engine_rst_ni),
        .clr_i         (clr_i),
        .inc_i         (stall),
        .count_o       (stall_count_o)
    );

endmodule
